// File: rtl/ws2812b_pkg.sv
// Shared WS2812B timing defaults and line-state encoding, used by both the
// receiver and the transmitter.
package ws2812b_pkg;

    localparam int T1_MIN_DEFAULT       = 38;
    localparam int HIGH_MAX_DEFAULT     = 96;
    localparam int RESET_CYCLES_DEFAULT = 3200;

    localparam int CNT_W   = 12;
    localparam int PIXEL_W = 24;

    typedef enum logic [1:0] {
        ST_IDLE     = 2'd0,
        ST_HIGH     = 2'd1,
        ST_LOW      = 2'd2,
        ST_WAIT_GAP = 2'd3
    } ws_state_e;

    // Pulse-width counters stick at full scale instead of wrapping.
    function automatic logic [CNT_W-1:0] satInc(input logic [CNT_W-1:0] v);
        return (v == {CNT_W{1'b1}}) ? v : v + 1'b1;
    endfunction

endpackage

// File: rtl/ws2812b_rx_sync.sv
// Two-flop synchronizer for the asynchronous serial line, plus a registered
// previous-level flop so rise/fall are single-cycle strobes.
module ws2812b_rx_sync
    import ws2812b_pkg::*;
(
    input  logic clk,
    input  logic rst_n,
    input  logic din,
    output logic level,
    output logic rise,
    output logic fall
);

    logic meta_q;
    logic sync_q;
    logic prev_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            meta_q <= 1'b0;
            sync_q <= 1'b0;
            prev_q <= 1'b0;
        end else begin
            meta_q <= din;
            sync_q <= meta_q;
            prev_q <= sync_q;
        end
    end

    assign level = sync_q;
    assign rise  = sync_q & ~prev_q;
    assign fall  = ~sync_q & prev_q;

endmodule

// File: rtl/ws2812b_rx.sv
// WS2812B receiver: measures high-pulse widths to decode bits, assembles
// 24-bit GRB words into a one-deep holding register and flags protocol errors.
module ws2812b_rx
    import ws2812b_pkg::*;
#(
    parameter int T1_MIN       = T1_MIN_DEFAULT,
    parameter int HIGH_MAX     = HIGH_MAX_DEFAULT,
    parameter int RESET_CYCLES = RESET_CYCLES_DEFAULT
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        din,
    output logic [23:0] pixel,
    output logic        valid,
    input  logic        ready,
    output logic        latch,
    output logic [7:0]  pixel_count,
    output logic        overrun,
    output logic        frame_err,
    input  logic        err_clr
);

    localparam logic [CNT_W-1:0] T1MinC     = CNT_W'(T1_MIN);
    localparam logic [CNT_W-1:0] HighMaxC   = CNT_W'(HIGH_MAX);
    localparam logic [CNT_W-1:0] ResetLastC = CNT_W'(RESET_CYCLES - 1);

    logic level;
    logic rise;
    logic fall;

    ws_state_e         state_q;
    logic [CNT_W-1:0]  high_cnt_q;
    logic [CNT_W-1:0]  low_cnt_q;
    logic [22:0]       shift_q;
    logic [4:0]        bit_cnt_q;
    logic [23:0]       pixel_q;
    logic              valid_q;
    logic              latch_q;
    logic [7:0]        pixel_count_q;
    logic              overrun_q;
    logic              frame_err_q;

    logic [23:0]       shift_d;
    logic              word_done;
    logic              latch_d;
    logic              high_err;
    logic              partial_latch;
    logic              overrun_set;

    ws2812b_rx_sync u_sync (
        .clk   (clk),
        .rst_n (rst_n),
        .din   (din),
        .level (level),
        .rise  (rise),
        .fall  (fall)
    );

    // Events for this cycle; a bit is 1 when the measured high time reached T1_MIN.
    always_comb begin
        shift_d       = {shift_q, (high_cnt_q >= T1MinC)};
        word_done     = (state_q == ST_HIGH) && fall && (bit_cnt_q == 5'd23);
        latch_d       = (state_q == ST_LOW) && !rise && (low_cnt_q >= ResetLastC);
        high_err      = (state_q == ST_HIGH) && !fall && (high_cnt_q > HighMaxC);
        partial_latch = latch_d && (bit_cnt_q != 5'd0);
        overrun_set   = word_done && valid_q && !ready;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q       <= ST_IDLE;
            high_cnt_q    <= '0;
            low_cnt_q     <= '0;
            shift_q       <= '0;
            bit_cnt_q     <= '0;
            pixel_q       <= '0;
            valid_q       <= 1'b0;
            latch_q       <= 1'b0;
            pixel_count_q <= '0;
            overrun_q     <= 1'b0;
            frame_err_q   <= 1'b0;
        end else begin
            latch_q <= latch_d;
            case (state_q)
                ST_IDLE: begin
                    if (rise) begin
                        high_cnt_q <= '0;
                        state_q    <= ST_HIGH;
                    end
                end
                ST_HIGH: begin
                    if (fall) begin
                        shift_q    <= shift_d[22:0];
                        bit_cnt_q  <= (bit_cnt_q == 5'd23) ? 5'd0 : bit_cnt_q + 5'd1;
                        low_cnt_q  <= '0;
                        state_q    <= ST_LOW;
                    end else if (high_err) begin
                        bit_cnt_q  <= '0;
                        low_cnt_q  <= '0;
                        state_q    <= ST_WAIT_GAP;
                    end else begin
                        high_cnt_q <= satInc(high_cnt_q);
                    end
                end
                ST_LOW: begin
                    if (rise) begin
                        high_cnt_q <= '0;
                        state_q    <= ST_HIGH;
                    end else if (latch_d) begin
                        bit_cnt_q  <= '0;
                        state_q    <= ST_IDLE;
                    end else begin
                        low_cnt_q  <= satInc(low_cnt_q);
                    end
                end
                ST_WAIT_GAP: begin
                    // Any high level restarts the gap measurement.
                    if (level) begin
                        low_cnt_q <= '0;
                    end else if (low_cnt_q >= ResetLastC) begin
                        state_q   <= ST_IDLE;
                    end else begin
                        low_cnt_q <= satInc(low_cnt_q);
                    end
                end
                default: state_q <= ST_IDLE;
            endcase

            if (word_done) begin
                if (!valid_q || ready) begin
                    pixel_q <= shift_d;
                    valid_q <= 1'b1;
                end
            end else if (valid_q && ready) begin
                valid_q <= 1'b0;
            end

            if (latch_d) begin
                pixel_count_q <= '0;
            end else if (word_done && (pixel_count_q != 8'hFF)) begin
                pixel_count_q <= pixel_count_q + 8'd1;
            end

            overrun_q   <= overrun_set | (overrun_q & ~err_clr);
            frame_err_q <= high_err | partial_latch | (frame_err_q & ~err_clr);
        end
    end

    assign pixel       = pixel_q;
    assign valid       = valid_q;
    assign latch       = latch_q;
    assign pixel_count = pixel_count_q;
    assign overrun     = overrun_q;
    assign frame_err   = frame_err_q;

endmodule

// File: tb/tb_ws2812b_rx.sv
// Self-checking bench for ws2812b_rx: expected pixels go into a scoreboard
// queue when driven and are popped whenever the receiver hands a word over.
module tb_ws2812b_rx;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        din = 1'b0;
    logic        ready = 1'b0;
    logic        err_clr = 1'b0;
    logic [23:0] pixel;
    logic        valid;
    logic        latch;
    logic [7:0]  pixel_count;
    logic        overrun;
    logic        frame_err;

    int checkCount = 0;
    int passCount = 0;
    int validCycles = 0;
    int latchCount = 0;
    int vc0;
    int lc0;
    logic [23:0] expQ[$];

    always #5 clk = ~clk;

    ws2812b_rx dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .din         (din),
        .pixel       (pixel),
        .valid       (valid),
        .ready       (ready),
        .latch       (latch),
        .pixel_count (pixel_count),
        .overrun     (overrun),
        .frame_err   (frame_err),
        .err_clr     (err_clr)
    );

    task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
        checkCount++;
        if (observed === expected) passCount++;
        else $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", tag, observed, expected);
    endtask

    task automatic holdLine(input logic lvl, input int cycles);
        din = lvl;
        repeat (cycles) @(negedge clk);
    endtask

    // Sends the top nBits of value MSB first with nominal 1/0 pulse shapes.
    task automatic applyStimulus(input logic [23:0] value, input int nBits);
        for (int i = 0; i < nBits; i++) begin
            if (value[23-i]) begin
                holdLine(1'b1, 51);
                holdLine(1'b0, 29);
            end else begin
                holdLine(1'b1, 26);
                holdLine(1'b0, 54);
            end
        end
    endtask

    task automatic pulseErrClr();
        err_clr = 1'b1;
        @(negedge clk);
        err_clr = 1'b0;
    endtask

    // Samples just after the falling edge so inputs changed there are settled.
    always @(negedge clk) begin
        #1;
        if (valid) validCycles++;
        if (latch) latchCount++;
        if (valid && ready) begin
            if (expQ.size() == 0) checkOutput("sbUnderflow", 32'(expQ.size()), 32'd1);
            else checkOutput("pixel", 32'(pixel), 32'(expQ.pop_front()));
        end
    end

    initial begin
        repeat (4) @(negedge clk);
        checkOutput("rstPixel", 32'(pixel), 32'd0);
        checkOutput("rstValid", 32'(valid), 32'd0);
        checkOutput("rstLatch", 32'(latch), 32'd0);
        checkOutput("rstCount", 32'(pixel_count), 32'd0);
        checkOutput("rstOverrun", 32'(overrun), 32'd0);
        checkOutput("rstFrameErr", 32'(frame_err), 32'd0);
        rst_n = 1'b1;
        ready = 1'b1;
        holdLine(1'b0, 10);

        vc0 = validCycles;
        expQ.push_back(24'hA5C3F0);
        applyStimulus(24'hA5C3F0, 24);
        holdLine(1'b0, 5);
        checkOutput("t1ValidCycles", 32'(validCycles - vc0), 32'd1);
        checkOutput("t1Count", 32'(pixel_count), 32'd1);
        checkOutput("t1SbEmpty", 32'(expQ.size()), 32'd0);

        lc0 = latchCount;
        holdLine(1'b0, 3300);
        checkOutput("t3Latches", 32'(latchCount - lc0), 32'd1);
        checkOutput("t3Count", 32'(pixel_count), 32'd0);
        checkOutput("t3FrameErr", 32'(frame_err), 32'd0);

        ready = 1'b0;
        applyStimulus(24'h112233, 24);
        applyStimulus(24'h445566, 24);
        holdLine(1'b0, 5);
        checkOutput("t2Pixel", 32'(pixel), 32'h112233);
        checkOutput("t2Valid", 32'(valid), 32'd1);
        checkOutput("t2Overrun", 32'(overrun), 32'd1);
        checkOutput("t2Count", 32'(pixel_count), 32'd2);
        pulseErrClr();
        checkOutput("t2OverrunClr", 32'(overrun), 32'd0);
        expQ.push_back(24'h112233);
        ready = 1'b1;
        holdLine(1'b0, 5);
        checkOutput("t2ValidDrop", 32'(valid), 32'd0);
        checkOutput("t2SbEmpty", 32'(expQ.size()), 32'd0);
        holdLine(1'b0, 3300);

        lc0 = latchCount;
        vc0 = validCycles;
        applyStimulus(24'hABCDEF, 10);
        holdLine(1'b0, 3300);
        checkOutput("t4Latches", 32'(latchCount - lc0), 32'd1);
        checkOutput("t4FrameErr", 32'(frame_err), 32'd1);
        checkOutput("t4NoValid", 32'(validCycles - vc0), 32'd0);
        checkOutput("t4Count", 32'(pixel_count), 32'd0);
        pulseErrClr();
        checkOutput("t4FrameErrClr", 32'(frame_err), 32'd0);
        expQ.push_back(24'h00FF00);
        applyStimulus(24'h00FF00, 24);
        holdLine(1'b0, 5);
        checkOutput("t4SbEmpty", 32'(expQ.size()), 32'd0);
        checkOutput("t4NextCount", 32'(pixel_count), 32'd1);
        holdLine(1'b0, 3300);

        lc0 = latchCount;
        vc0 = validCycles;
        applyStimulus(24'h5A5A5A, 5);
        holdLine(1'b1, 120);
        holdLine(1'b0, 5);
        checkOutput("t5FrameErr", 32'(frame_err), 32'd1);
        holdLine(1'b0, 1000);
        applyStimulus(24'hFFFFFF, 24);
        holdLine(1'b0, 3300);
        checkOutput("t5NoValid", 32'(validCycles - vc0), 32'd0);
        checkOutput("t5NoLatch", 32'(latchCount - lc0), 32'd0);
        checkOutput("t5CountHeld", 32'(pixel_count), 32'd0);
        expQ.push_back(24'h0000FF);
        applyStimulus(24'h0000FF, 24);
        holdLine(1'b0, 5);
        checkOutput("t5SbEmpty", 32'(expQ.size()), 32'd0);
        checkOutput("t5Count", 32'(pixel_count), 32'd1);
        holdLine(1'b0, 3300);

        ready = 1'b0;
        applyStimulus(24'h0F0F0F, 24);
        applyStimulus(24'hF0F0F0, 24);
        applyStimulus(24'h123456, 12);
        din = 1'b1;
        repeat (20) @(negedge clk);
        @(posedge clk);
        #3;
        rst_n = 1'b0;
        #1;
        checkOutput("t6Pixel", 32'(pixel), 32'd0);
        checkOutput("t6Valid", 32'(valid), 32'd0);
        checkOutput("t6Latch", 32'(latch), 32'd0);
        checkOutput("t6Count", 32'(pixel_count), 32'd0);
        checkOutput("t6Overrun", 32'(overrun), 32'd0);
        checkOutput("t6FrameErr", 32'(frame_err), 32'd0);
        din = 1'b0;
        repeat (5) @(negedge clk);
        rst_n = 1'b1;
        ready = 1'b1;
        holdLine(1'b0, 10);
        expQ.push_back(24'h123456);
        applyStimulus(24'h123456, 24);
        holdLine(1'b0, 5);
        checkOutput("t6SbEmpty", 32'(expQ.size()), 32'd0);
        checkOutput("t6NextCount", 32'(pixel_count), 32'd1);
        checkOutput("t6NextFrameErr", 32'(frame_err), 32'd0);

        $display("%0d/%0d checks passed", passCount, checkCount);
        $finish;
    end

endmodule
